sevenseg_scan_driver: RTL

//   Time-multiplexed seven-segment display driver for the score/timer digit chain.

---
 rtl/sevenseg_scan_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: double-buffered digit snapshot, per-slot guard blank,
// leading-zero suppression and registered segment/anode outputs of selectable polarity.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_blank_en,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame
);

  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [PRESC_W-1:0] GUARD_END  = PRESC_W'(GUARD);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Inactive pin level; XOR with it turns an active-high pattern into pin polarity.
  localparam logic POL = ACTIVE_LOW;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  logic [PRESC_W-1:0]      r_presc;
  logic [IDX_W-1:0]        r_index;
  logic                    r_tick_d;
  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_shadow_digits;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame;

  logic                    w_slot_end;
  logic                    w_tick;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_zero_run;
  logic [3:0]              w_digit;
  logic                    w_drive;
  logic [NUM_DIGITS-1:0]   w_an_onehot;

  assign w_slot_end = (r_presc == PRESC_LAST);
  assign w_tick     = w_slot_end && (r_index == IDX_LAST);

  // A digit is suppressed while it and every more significant digit are zero with no dp.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_blank    = '0;
    w_zero_run = i_blank_en;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run && (r_shadow_digits[4*k +: 4] == 4'd0) && !r_shadow_dp[k];
      w_blank[k] = w_zero_run;
    end
  end

  always_comb begin
    w_digit     = r_shadow_digits[{r_index, 2'b00} +: 4];
    w_drive     = (r_presc >= GUARD_END) && !w_blank[r_index];
    w_an_onehot = NUM_DIGITS'(1) << r_index;
  end

  // NOTE: all state here is non-blocking so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc         <= '0;
      r_index         <= '0;
      r_tick_d        <= 1'b0;
      r_pend_digits   <= '0;
      r_pend_dp       <= '0;
      r_pend_valid    <= 1'b0;
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
      r_seg           <= {7{POL}};
      r_dp            <= POL;
      r_an            <= {NUM_DIGITS{POL}};
      r_frame         <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_presc <= '0;
        r_index <= (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end

      // Delayed so the pulse lines up with the first pin cycle of digit 0.
      r_tick_d <= w_tick;
      r_frame  <= r_tick_d;

      if (w_tick) begin
        if (i_load) begin
          r_shadow_digits <= i_digits;
          r_shadow_dp     <= i_dp;
        end else if (r_pend_valid) begin
          r_shadow_digits <= r_pend_digits;
          r_shadow_dp     <= r_pend_dp;
        end
        r_pend_valid <= 1'b0;
      end else if (i_load) begin
        r_pend_digits <= i_digits;
        r_pend_dp     <= i_dp;
        r_pend_valid  <= 1'b1;
      end

      if (w_drive) begin
        r_seg <= decode(w_digit) ^ {7{POL}};
        r_dp  <= r_shadow_dp[r_index] ^ POL;
        r_an  <= w_an_onehot ^ {NUM_DIGITS{POL}};
      end else begin
        r_seg <= {7{POL}};
        r_dp  <= POL;
        r_an  <= {NUM_DIGITS{POL}};
      end
    end
  end

  assign o_seg   = r_seg;
  assign o_dp    = r_dp;
  assign o_an    = r_an;
  assign o_frame = r_frame;

endmodule
